// File: rtl/fc_backward_layer_if.sv
// fc_backward_layer_if: start/delta/weight inputs and result stream of fc_backward_layer
interface fc_backward_layer_if #(parameter int bitwidth = 32, parameter int VEC_LEN = 10);
  logic start;
  logic [bitwidth-1:0] delta_in [VEC_LEN];
  logic [bitwidth-1:0] connect_matrix [VEC_LEN][VEC_LEN];
  logic busy;
  logic out_valid;
  logic out_ready;
  logic [bitwidth-1:0] out_data;
  logic [3:0] out_index;
  logic done;
  modport master (output start, delta_in, connect_matrix, out_ready,
                  input busy, out_valid, out_data, out_index, done);
  modport slave (input start, delta_in, connect_matrix, out_ready,
                 output busy, out_valid, out_data, out_index, done);
endinterface

// File: rtl/fc_backward_layer.sv
// fc_backward_layer: sequential transposed mat-vec grad[j]=sum_i W[i][j]*delta[i], one MAC/cycle; GRAD_SAT_EN selects saturating grads
module fc_backward_layer #(
  parameter int bitwidth = 32,
  parameter int VEC_LEN = 10
) (
  input logic clk,
  input logic rst,
  fc_backward_layer_if.slave bus
);
`ifdef GRAD_SAT_EN
  localparam int AW = 2*bitwidth+4;
`else
  localparam int AW = bitwidth;
`endif
  localparam logic [3:0] LAST = 4'(VEC_LEN-1);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nx;
  logic [3:0] i, j, k, k_nx;
  logic [bitwidth-1:0] delta_reg [VEC_LEN];
  logic [bitwidth-1:0] grad [VEC_LEN];
  logic [AW-1:0] acc, sum;
  logic [bitwidth-1:0] w, d, grad_val;
  logic accept, hs, last_hs, valid_nx;
  always_comb begin
    w = bus.connect_matrix[i][j];
    d = delta_reg[i];
`ifdef GRAD_SAT_EN
    sum = acc + {4'b0, {{bitwidth{1'b0}}, w} * {{bitwidth{1'b0}}, d}};
    grad_val = |sum[AW-1:bitwidth] ? '1 : sum[bitwidth-1:0];
`else
    sum = acc + w * d;
    grad_val = sum;
`endif
  end
  // start is blocked on the done cycle: that cycle still counts as leaving OUT
  always_comb begin
    accept = state == IDLE && bus.start && !bus.done;
    hs = bus.out_valid && bus.out_ready;
    last_hs = state == OUT && hs && k == LAST;
  end
  always_comb
    state_nx = state == IDLE ? (accept ? MAC : IDLE)
             : state == MAC ? ((i == LAST && j == LAST) ? OUT : MAC)
             : (last_hs ? IDLE : OUT);
  always_comb begin
    bus.busy = state != IDLE;
    valid_nx = state == OUT && !last_hs;
    k_nx = (hs && !last_hs) ? k + 4'd1 : k;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      k <= '0;
      acc <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_index <= '0;
      bus.done <= 1'b0;
      for (int n = 0; n < VEC_LEN; n++) begin
        delta_reg[n] <= '0;
        grad[n] <= '0;
      end
    end else begin
      state <= state_nx;
      bus.out_valid <= valid_nx;
      bus.done <= last_hs;
      k <= k_nx;
      if (valid_nx) begin
        bus.out_data <= grad[k_nx];
        bus.out_index <= k_nx;
      end
      if (accept) begin
        delta_reg <= bus.delta_in;
        acc <= '0;
        i <= '0;
        j <= '0;
        k <= '0;
      end else if (state == MAC) begin
        if (i == LAST) begin
          grad[j] <= grad_val;
          acc <= '0;
          i <= '0;
          j <= (j == LAST) ? 4'd0 : j + 4'd1;
        end else begin
          acc <= sum;
          i <= i + 4'd1;
        end
      end
    end
endmodule

// File: tb/tb_fc_backward_layer.sv
// tb_fc_backward_layer: directed checks of fc_backward_layer results, latency, backpressure, start filtering and reset
module tb_fc_backward_layer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fc_backward_layer_if #(.bitwidth(32), .VEC_LEN(10)) bus ();
  fc_backward_layer #(.bitwidth(32), .VEC_LEN(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_g [10];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs;
    for (int a = 0; a < 10; a++) begin
      bus.delta_in[a] = '0;
      for (int b = 0; b < 10; b++) bus.connect_matrix[a][b] = '0;
    end
  endtask
  task automatic load_identity;
    clear_inputs();
    for (int a = 0; a < 10; a++) begin
      bus.connect_matrix[a][a] = 32'd1;
      bus.delta_in[a] = 32'(a + 1);
      exp_g[a] = 32'(a + 1);
    end
  endtask
  // mode 0: ready high, 1: 5-cycle stall at index 3, 2: random ready
  task automatic run(input int mode, input bit inject, input string tag);
    int lat = 0;
    int cyc = 0;
    int got = 0;
    int stall = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (!bus.out_valid && lat < 300) begin
      if (inject && lat == 50) begin
        bus.start = 1'b1;
        for (int a = 0; a < 10; a++) bus.delta_in[a] = 32'd7;
      end
      tick();
      lat++;
      bus.start = 1'b0;
    end
    check({tag, "_latency"}, 32'(lat), 32'd101);
    while (got < 10 && cyc < 300) begin
      bus.out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1 && bus.out_valid && bus.out_index == 4'd3 && stall < 5) begin
        bus.out_ready = 1'b0;
        stall++;
        check({tag, "_bp_idx"}, 32'(bus.out_index), 32'd3);
        check({tag, "_bp_data"}, bus.out_data, exp_g[3]);
      end
      if (bus.out_valid && bus.out_ready) begin
        check({tag, "_idx"}, 32'(bus.out_index), 32'(got));
        check({tag, "_data"}, bus.out_data, exp_g[got]);
        got++;
      end
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    check({tag, "_count"}, 32'(got), 32'd10);
    if (mode == 0) check({tag, "_done_lat"}, 32'(lat + cyc), 32'd111);
    if (mode == 1) check({tag, "_stalls"}, 32'(stall), 32'd5);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, "_valid_end"}, 32'(bus.out_valid), 32'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    clear_inputs();
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_data", bus.out_data, 32'd0);
    check("rst_index", 32'(bus.out_index), 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
    check("start_in_rst", 32'(bus.busy), 32'd0);
    load_identity();
    run(0, 1'b0, "ident");
    tick();
    check("done_pulse", 32'(bus.done), 32'd0);
    clear_inputs();
    for (int a = 0; a < 10; a++) begin
      bus.delta_in[a] = 32'd3;
      exp_g[a] = 32'd30;
      for (int b = 0; b < 10; b++) bus.connect_matrix[a][b] = 32'd1;
    end
    run(2, 1'b0, "ones");
    tick();
    clear_inputs();
    for (int a = 0; a < 10; a++) begin
      bus.delta_in[a] = 32'd1;
      exp_g[a] = 32'd45;
      for (int b = 0; b < 10; b++) bus.connect_matrix[a][b] = 32'(a);
    end
    run(1, 1'b1, "transp");
    tick();
    clear_inputs();
    bus.connect_matrix[0][0] = 32'hFFFF_FFFF;
    bus.delta_in[0] = 32'd2;
    for (int a = 0; a < 10; a++) exp_g[a] = '0;
`ifdef GRAD_SAT_EN
    exp_g[0] = 32'hFFFF_FFFF;
`else
    exp_g[0] = 32'hFFFF_FFFE;
`endif
    run(0, 1'b0, "ovf");
    load_identity();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_on_done", 32'(bus.busy), 32'd0);
    run(0, 1'b0, "after_done");
    tick();
    for (int a = 0; a < 10; a++) bus.delta_in[a] = 32'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_mac", 32'(bus.busy), 32'd1);
    repeat (40) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_data", bus.out_data, 32'd0);
    load_identity();
    run(0, 1'b0, "post_rst");
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
